// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receiver state and default frame geometry,
// common to the transmit and receive paths.
package i2s_pkg;
    localparam int SAMPLE_WIDTH_DEF = 16;
    localparam int SLOT_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        SYNC,
        LEFT,
        RIGHT
    } rx_state_t;
endpackage

// File: rtl/i2s_rx_if.sv
// Parallel sample-pair stream with valid/ready handshake.
interface i2s_rx_if
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
) ();
    logic [SAMPLE_WIDTH-1:0] left_sample;
    logic [SAMPLE_WIDTH-1:0] right_sample;
    logic out_valid;
    logic out_ready;

    modport master (
        output left_sample,
        output right_sample,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  left_sample,
        input  right_sample,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/i2s_rx_sync_edge.sv
// Two-flop synchroniser with a delayed copy and registered edge pulses.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic s1;
    logic s2;

    // q is delayed one cycle so it lines up with the edge pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            q    <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            q    <= s2;
            rise <= s2 & ~q;
            fall <= ~s2 & q;
        end
    end
endmodule

// File: rtl/i2s_rx.sv
// Philips I2S receiver, oversampled on the system clock.
// Define I2S_RX_FRAME_CHECK_EN to flag and drop mis-sized half-frames.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int SLOT_WIDTH = SLOT_WIDTH_DEF
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     frame_clk,
    input  logic     bit_clk,
    input  logic     adc_sdata,
    input  logic     clear_flags,
    output logic     overrun,
    output logic     frame_err,
    i2s_rx_if.master rx
);
    localparam int CW = $clog2(SLOT_WIDTH + 1);

    logic ws, ws_rise, ws_fall;
    logic bit_ev, bclk_fall, bclk_q;
    logic d1, d2, sd;
    logic ws_prev, drop, chk_fail, change;
    logic [CW-1:0] cnt;
    logic [31:0] cnt32;
    logic [SAMPLE_WIDTH-1:0] sr, sr_in, fin, left_hold;
    rx_state_t state;
    logic unused_edges;

    sync_edge u_bclk (
        .clk(clk), .reset(reset), .d(bit_clk),
        .q(bclk_q), .rise(bit_ev), .fall(bclk_fall)
    );

    sync_edge u_ws (
        .clk(clk), .reset(reset), .d(frame_clk),
        .q(ws), .rise(ws_rise), .fall(ws_fall)
    );

    assign unused_edges = ws_rise | ws_fall | bclk_fall | bclk_q;

    // data takes the same three-stage path as ws and bit_clk
    always_ff @(posedge clk) begin
        if (reset) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
            sd <= 1'b0;
        end else begin
            d1 <= adc_sdata;
            d2 <= d1;
            sd <= d2;
        end
    end

    assign cnt32 = 32'(cnt);
    assign change = bit_ev && (ws != ws_prev);

    always_comb begin
        sr_in = sr;
        if (cnt32 < 32'(SAMPLE_WIDTH))
            sr_in = {sr[SAMPLE_WIDTH-2:0], sd};
        fin = sr_in;
        // short slot: left-align what arrived, zero the missing LSBs
        if (cnt32 + 32'd1 < 32'(SAMPLE_WIDTH))
            fin = sr_in << (32'(SAMPLE_WIDTH) - 32'd1 - cnt32);
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    logic ferr_q;

    assign chk_fail = (state != SYNC) &&
                      (cnt32 + 32'd1 != 32'(SLOT_WIDTH));

    always_ff @(posedge clk) begin
        if (reset)
            ferr_q <= 1'b0;
        else if (change && chk_fail)
            ferr_q <= 1'b1;
        else if (clear_flags)
            ferr_q <= 1'b0;
    end

    assign frame_err = ferr_q;
`else
    assign chk_fail = 1'b0;
    assign frame_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= SYNC;
            ws_prev         <= 1'b0;
            cnt             <= '0;
            sr              <= '0;
            left_hold       <= '0;
            drop            <= 1'b0;
            overrun         <= 1'b0;
            rx.out_valid    <= 1'b0;
            rx.left_sample  <= '0;
            rx.right_sample <= '0;
        end else begin
            if (rx.out_valid && rx.out_ready)
                rx.out_valid <= 1'b0;
            if (clear_flags)
                overrun <= 1'b0;
            if (bit_ev) begin
                ws_prev <= ws;
                if (change) begin
                    cnt <= '0;
                    sr  <= '0;
                    unique case (state)
                        SYNC: begin
                            if (!ws)
                                state <= LEFT;
                        end
                        LEFT: begin
                            left_hold <= fin;
                            drop      <= chk_fail;
                            state     <= RIGHT;
                        end
                        RIGHT: begin
                            if (!drop && !chk_fail) begin
                                rx.left_sample  <= left_hold;
                                rx.right_sample <= fin;
                                rx.out_valid    <= 1'b1;
                                if (rx.out_valid && !rx.out_ready)
                                    overrun <= 1'b1;
                            end
                            drop  <= 1'b0;
                            state <= LEFT;
                        end
                        default: state <= SYNC;
                    endcase
                end else begin
                    sr <= sr_in;
                    if (cnt32 < 32'(SLOT_WIDTH))
                        cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Receive-side counterpart of the codec serial transmit path.
- Deserialises the codec ADC data line (Philips I2S: MSB one bit_clk after the frame_clk edge; frame_clk low = left, high = right) into parallel left/right sample pairs.
- Presents each pair on a valid/ready interface to downstream logic (meters, loopback, seven-seg debug).
- Runs entirely on the 50 MHz system clock. frame_clk, bit_clk and the data line are sampled inputs, never used as clocks.

Parameters:
SAMPLE_WIDTH, 16, bits kept per channel; MSB-first, extra slot bits ignored
SLOT_WIDTH, 32, bit_clk periods per channel half-frame (used for framing check)

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
frame_clk  in  1  codec word select; asynchronous to clk
bit_clk  in  1  codec bit clock; asynchronous to clk; each phase at least 2 clk periods
adc_sdata  in  1  codec serial ADC data
left_sample  out  SAMPLE_WIDTH  left channel, two's complement
right_sample  out  SAMPLE_WIDTH  right channel, two's complement
out_valid  out  1  pair available; held until accepted
out_ready  in  1  consumer accepts pair when out_valid && out_ready
overrun  out  1  sticky: a new pair overwrote an unaccepted one
frame_err  out  1  sticky: half-frame bit count != SLOT_WIDTH (feature-gated)
clear_flags  in  1  one-cycle pulse clears overrun and frame_err

Behaviour:
- Reset values: all outputs 0; state = SYNC; shift registers and bit counter 0.
- Input conditioning:
  - frame_clk, bit_clk and adc_sdata each pass through a 2-flop synchroniser.
  - A rising edge of bit_clk is detected one cycle later from the synchronised bit_clk and its delayed copy.
  - ws and data are sampled from their synchronised copies on that same cycle, so the three stay aligned.
- On each detected bit_clk rising edge ("bit event"), compare ws with ws_prev (ws at the previous bit event):
  - Change edge (ws != ws_prev):
    - The sampled bit is the LSB-slot bit of the previous channel; shift it in if cnt < SAMPLE_WIDTH.
    - Finalise that channel.
    - Reset cnt to 0.
  - Otherwise:
    - Shift the bit into the current channel (channel = ws) if cnt < SAMPLE_WIDTH.
    - cnt increments and saturates at SLOT_WIDTH.
- Channel bits per half-frame = cnt + 1 at finalise. If this is less than SAMPLE_WIDTH, left-align the sample and zero-pad the LSBs.
- State machine:
  - SYNC: ignore all data. At a 1->0 change edge, go to LEFT with no output.
  - LEFT: at a 0->1 change edge, latch the left shift register into left_hold and go to RIGHT.
  - RIGHT: at a 1->0 change edge, load left_sample/right_sample and set out_valid, then go to LEFT.
  - A 0->1 edge seen in SYNC stays in SYNC.
- Latency: out_valid rises on the 4th clk edge after the raw bit_clk rising edge that carries the right LSB-slot bit (2 sync + 1 edge detect + 1 register).
- Handshake:
  - out_valid falls the cycle after out_valid && out_ready.
  - Outputs are stable while out_valid=1 and not accepted.
- Boundary conditions:
  - Pair completes while out_valid=1 and out_ready=0: the new pair overwrites, out_valid stays 1, and overrun is set.
  - Completion in the same cycle as acceptance: the new pair loads, out_valid stays 1, and no overrun.
  - clear_flags in the same cycle as a set condition: set wins.
  - reset mid-frame: return to SYNC and discard partial data. The first pair is emitted only after a full left+right following the next 1->0 edge.

Optional Feature:
- Macro: I2S_RX_FRAME_CHECK_EN
- When defined:
  - At every change edge outside SYNC, if cnt+1 != SLOT_WIDTH, set frame_err.
  - If that check fails in LEFT or RIGHT, the pair in progress is discarded: no out_valid, and the state still advances normally.
- When undefined: no check; frame_err is tied 0; every completed pair is emitted.

Decomposition:
- Shared package i2s_pkg holds:
  - the state enum {SYNC, LEFT, RIGHT};
  - default SAMPLE_WIDTH/SLOT_WIDTH constants, shared with the transmit side.
- One sub-module sync_edge (2-flop synchroniser plus rise/fall pulse outputs), instantiated for bit_clk and frame_clk. adc_sdata uses the plain synchronised output.

Test Plan:
- Reset, then 3 I2S frames (32-bit slots) with L=16'h1234, R=16'hABCD -> first pair discarded in SYNC; subsequent out_valid with left_sample=1234, right_sample=ABCD; out_valid high exactly 4 clk after the raw bit_clk edge carrying the right LSB-slot bit.
- out_ready held 0 across two frames (L=0001/R=0002 then L=0003/R=0004) -> outputs show 0003/0004, overrun=1; clear_flags pulse -> overrun=0.
- out_ready=1 continuously with L=8000/R=7FFF -> one out_valid cycle per frame, values exact, overrun stays 0.
- With I2S_RX_FRAME_CHECK_EN: one right half-frame of 31 bits -> frame_err=1, that pair not emitted; next correct frame emitted normally.
- Slot of 12 bits with SAMPLE_WIDTH=16, check disabled, data 12'hFFF -> sample = 16'hFFF0.
- reset asserted mid-left-slot -> outputs 0 next cycle; no out_valid until a full frame after the next 1->0 frame_clk edge.
